axis_cobs_decoder: RTL
======================

Name: axis_cobs_decoder

Overview:
Receive-side counterpart to the accelerometer COBS encoder path. Consumes the raw byte stream from the UART RX (0x00-delimited COBS frames from the host), removes the COBS framing, and emits decoded frames as an 8-bit AXI-Stream with tlast on the final byte. Downstream is the command/config consumer. Throughput is one input byte per cycle.

Parameters:
MAX_FRAME_LEN, 256, maximum decoded bytes per frame; exceeding it is a length error.
LEN_WIDTH, $clog2(MAX_FRAME_LEN+1), width of the internal decoded-length counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-low reset.
s_tdata  input  8  encoded byte from the UART RX stream.
s_tvalid  input  1  input byte valid.
s_tready  output  1  input accepted when s_tvalid && s_tready.
m_tdata  output  8  decoded byte.
m_tvalid  output  1  output valid.
m_tready  input  1  downstream ready.
m_tlast  output  1  last byte of the decoded frame.
m_tuser  output  1  frame error, qualified with m_tlast.
frame_error  output  1  one-cycle pulse on any framing or length error.

Behaviour:
- Interface rule: one clock, clk. Reset is synchronous and active-low on port reset.
- Reset values: m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, frame_error=0, state=IDLE, hold register empty. s_tready=1 during the first cycle after reset deassertion.
- Hold register: one-entry {data, last, user}. A decoded byte is held until the next decoded byte arrives or a delimiter arrives, so that tlast can be set on the true last byte.
  - The hold register drives m_* directly.
  - It empties on an m_tvalid && m_tready handshake unless it is refilled in the same cycle.
- Backpressure: s_tready = !hold_valid || m_tready. Each accepted input byte produces at most one hold write, so no loss and no extra buffering.
- Input-to-output latency: the byte is held until the next decoded byte or delimiter is accepted, then it is registered out. m_* is stable while m_tvalid && !m_tready.
- Group counter rem (8b) and flag last_code_ff.
- States:
  - IDLE:
    - Byte 0x00: ignored (empty frame, no output).
    - Byte c≠0: rem=c-1, last_code_ff=(c==0xFF), len=0. Go to DATA if c>1, else CODE.
  - DATA:
    - Byte 0x00: error. If hold_valid, mark the held byte last=1, user=1. Pulse frame_error. Go to IDLE.
    - Else: write the byte to the hold register, len++, rem--. When rem reaches 0, go to CODE.
  - CODE:
    - Byte 0x00: end of frame. If hold_valid, set last=1, user=0. Go to IDLE. An empty decoded frame (e.g. 01 00) produces no output.
    - Byte c≠0: if !last_code_ff, write 0x00 to the hold register (len++). Load rem/last_code_ff from c. Go to DATA if c>1, else stay in CODE.
  - DISCARD:
    - All bytes are consumed and dropped until 0x00, then go to IDLE.
- Length error: if a hold write would make len exceed MAX_FRAME_LEN, the write is suppressed. The currently held byte is marked last=1, user=1; frame_error pulses; go to DISCARD.
  - If the offending byte is the first of the frame, nothing is emitted and frame_error still pulses.
- Writing a new byte into the hold register while an old byte is held releases the old byte with last=0. Ordering is preserved by the s_tready rule.
- Reset asserted mid-frame: the hold register and any partial frame are dropped with no tlast emitted. Decoding restarts in IDLE.

Optional Feature:
COBS_DECODER_STATS_EN
- Defined: adds output ports frame_count[15:0] and error_count[15:0].
  - Both are saturating counters, cleared by reset.
  - frame_count increments on each non-empty, error-free frame close.
  - error_count increments on each frame_error pulse.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package cobs_pkg holds:
  - COBS_DELIM=8'h00 and COBS_MAX_CODE=8'hFF, shared with the encoder;
  - the decoder state enum {IDLE, DATA, CODE, DISCARD};
  - a packed hold_entry_t {data[7:0], last, user}.
- Sub-module axis_hold_reg: the one-entry hold register plus the ready logic. It is reusable by the encoder.

Test Plan:
1. Input 03 11 22 02 33 00 with m_tready=1 → output 11, 22, 00, 33; tlast only on 33; tuser=0; no frame_error.
2. Input FF 01..FE, then 00 → 254 bytes 01..FE with no inserted zero; tlast on FE.
3. Input 05 AA BB 00 → AA, then BB with tlast=1 and tuser=1; frame_error pulses for exactly 1 cycle. The next frame 02 44 00 → 44 with tlast and tuser=0.
4. With MAX_FRAME_LEN=4, input 06 01 02 03 04 05 00 → 01 02 03 04, tlast and tuser=1 on 04, one frame_error pulse, 05 dropped. Input 00 00 01 00 → no output.
5. Scenario 1 with m_tready held low for 10 cycles after the first output → s_tready low; m_tdata/m_tvalid stable; output identical, no loss or duplication.
6. Reset low for 1 cycle after the input 04 AA BB → no output; all outputs at reset values. Then 02 CC 00 → CC with tlast.

Source files
------------

// File: rtl/cobs_pkg.sv
// Constants and types shared by the COBS encoder and decoder paths.
package cobs_pkg;

  localparam logic [7:0] COBS_DELIM    = 8'h00;
  localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StCode,
    StDiscard
  } dec_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } hold_entry_t;

endpackage

// File: rtl/axis_hold_reg.sv
// One-entry AXI-Stream output register; accepts a write whenever it is empty or draining.
module axis_hold_reg
  import cobs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  hold_entry_t wr_entry_i,
  output logic        wr_ready_o,
  output hold_entry_t m_entry_o,
  output logic        m_valid_o,
  input  logic        m_ready_i
);

  logic        valid_q, valid_d;
  hold_entry_t entry_q, entry_d;

  assign wr_ready_o = !valid_q || m_ready_i;
  assign m_valid_o  = valid_q;
  assign m_entry_o  = entry_q;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end
    // A refill in the same cycle as a handshake keeps the register full.
    if (wr_en_i) begin
      valid_d = 1'b1;
      entry_d = wr_entry_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/axis_cobs_decoder.sv
// COBS frame decoder: 0x00-delimited byte stream in, AXI-Stream frames with tlast/tuser out.
// Define COBS_DECODER_STATS_EN to add saturating frame_count/error_count outputs.
module axis_cobs_decoder
  import cobs_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = 256,
  parameter int unsigned LEN_WIDTH     = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        frame_error
`ifdef COBS_DECODER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
`endif
);

  dec_state_e           state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic                 last_code_ff_q, last_code_ff_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [7:0]           pend_data_q, pend_data_d;
  logic                 frame_error_q, err_d, close_d;

  logic        accept, out_we, out_ready, push_req;
  logic [7:0]  push_byte;
  hold_entry_t out_entry, m_entry;

  assign s_tready    = out_ready;
  assign accept      = s_tvalid && out_ready;
  assign frame_error = frame_error_q;
  assign m_tdata     = m_entry.data;
  assign m_tlast     = m_entry.last;
  assign m_tuser     = m_entry.user;

  // The newest decoded byte waits in pend_* until the next byte or delimiter decides its tlast.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    last_code_ff_d = last_code_ff_q;
    len_d          = len_q;
    pend_valid_d   = pend_valid_q;
    pend_data_d    = pend_data_q;
    err_d          = 1'b0;
    close_d        = 1'b0;
    out_we         = 1'b0;
    out_entry      = '{data: pend_data_q, last: 1'b0, user: 1'b0};
    push_req       = 1'b0;
    push_byte      = COBS_DELIM;

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (s_tdata != COBS_DELIM) begin
            rem_d          = s_tdata - 8'd1;
            last_code_ff_d = (s_tdata == COBS_MAX_CODE);
            len_d          = '0;
            state_d        = (s_tdata > 8'd1) ? StData : StCode;
          end
        end
        StData: begin
          if (s_tdata == COBS_DELIM) begin
            out_we         = pend_valid_q;
            out_entry.last = 1'b1;
            out_entry.user = 1'b1;
            pend_valid_d   = 1'b0;
            err_d          = 1'b1;
            state_d        = StIdle;
          end else begin
            push_req  = 1'b1;
            push_byte = s_tdata;
            rem_d     = rem_q - 8'd1;
            state_d   = (rem_q == 8'd1) ? StCode : StData;
          end
        end
        StCode: begin
          if (s_tdata == COBS_DELIM) begin
            out_we         = pend_valid_q;
            out_entry.last = 1'b1;
            close_d        = pend_valid_q;
            pend_valid_d   = 1'b0;
            state_d        = StIdle;
          end else begin
            push_req       = !last_code_ff_q;
            rem_d          = s_tdata - 8'd1;
            last_code_ff_d = (s_tdata == COBS_MAX_CODE);
            state_d        = (s_tdata > 8'd1) ? StData : StCode;
          end
        end
        StDiscard: begin
          if (s_tdata == COBS_DELIM) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (push_req) begin
        if (len_q == LEN_WIDTH'(MAX_FRAME_LEN)) begin
          out_we         = pend_valid_q;
          out_entry.last = 1'b1;
          out_entry.user = 1'b1;
          pend_valid_d   = 1'b0;
          err_d          = 1'b1;
          state_d        = StDiscard;
        end else begin
          out_we       = pend_valid_q;
          pend_data_d  = push_byte;
          pend_valid_d = 1'b1;
          len_d        = len_q + LEN_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      rem_q          <= '0;
      last_code_ff_q <= 1'b0;
      len_q          <= '0;
      pend_valid_q   <= 1'b0;
      pend_data_q    <= '0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      last_code_ff_q <= last_code_ff_d;
      len_q          <= len_d;
      pend_valid_q   <= pend_valid_d;
      pend_data_q    <= pend_data_d;
      frame_error_q  <= err_d;
    end
  end

  axis_hold_reg u_hold (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr_en_i    (out_we),
    .wr_entry_i (out_entry),
    .wr_ready_o (out_ready),
    .m_entry_o  (m_entry),
    .m_valid_o  (m_tvalid),
    .m_ready_i  (m_tready)
  );

`ifdef COBS_DECODER_STATS_EN
  logic [15:0] frame_count_q, error_count_q;

  assign frame_count = frame_count_q;
  assign error_count = error_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      if (close_d && (frame_count_q != 16'hFFFF)) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (err_d && (error_count_q != 16'hFFFF)) begin
        error_count_q <= error_count_q + 16'd1;
      end
    end
  end
`endif

endmodule
